// File: rtl/hes_stream_decipher.sv
// rtl/hes_stream_decipher.sv - HES stream decipher: keyed S-box keystream XOR feeding an output FIFO
module hes_stream_decipher #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sof,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic [7:0] out_index,
  output logic       err_orphan
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH[CNT_W:0];

  // Shared HES S-box, row = ctr[7:4], column = ctr[3:0]
  localparam logic [0:15][0:15][7:0] SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       ctr_q, ctr_d;
  logic [7:0]       idx_q, idx_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_sof_q, s1_sof_d;
  logic [7:0]       s1_data_q, s1_data_d;
  logic [7:0]       s1_ctr_q, s1_ctr_d;
  logic [7:0]       s1_idx_q, s1_idx_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s2_sof_q, s2_sof_d;
  logic [7:0]       s2_data_q, s2_data_d;
  logic [7:0]       s2_idx_q, s2_idx_d;
  logic             err_q, err_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [16:0]      mem_q [FIFO_DEPTH];

  logic             accept;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   occ;
  logic [16:0]      rd_entry;

  // Handshake and credit: a byte popped this cycle frees its slot for a byte accepted this cycle
  always_comb begin
    out_valid = (count_q != '0);
    pop       = out_valid & out_ready;
    push      = s2_valid_q;
    occ       = {1'b0, count_q} + {{CNT_W{1'b0}}, s1_valid_q} + {{CNT_W{1'b0}}, s2_valid_q}
              - {{CNT_W{1'b0}}, pop};
    in_ready  = rst_n & (occ < DEPTH_C);
    accept    = in_valid & in_ready;
    rd_entry  = mem_q[rd_ptr_q];
    out_data  = out_valid ? rd_entry[7:0]  : 8'h00;
    out_index = out_valid ? rd_entry[15:8] : 8'h00;
    out_sof   = out_valid & rd_entry[16];
    err_orphan = err_q;
  end

  // Message tracking, stage 1 capture, stage 2 keystream XOR and FIFO pointer bookkeeping
  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    idx_d      = idx_q;
    err_d      = 1'b0;
    s1_valid_d = 1'b0;
    s1_sof_d   = s1_sof_q;
    s1_data_d  = s1_data_q;
    s1_ctr_d   = s1_ctr_q;
    s1_idx_d   = s1_idx_q;
    if (accept) begin
      if (in_sof) begin
        state_d    = ST_ACTIVE;
        ctr_d      = key;
        idx_d      = 8'h00;
        s1_valid_d = 1'b1;
      end else if (state_q == ST_ACTIVE) begin
        ctr_d      = ctr_q + 8'd1;
        idx_d      = idx_q + 8'd1;
        s1_valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (s1_valid_d) begin
      s1_sof_d  = in_sof;
      s1_data_d = in_data;
      s1_ctr_d  = ctr_d;
      s1_idx_d  = idx_d;
    end

    s2_valid_d = s1_valid_q;
    s2_sof_d   = s2_sof_q;
    s2_data_d  = s2_data_q;
    s2_idx_d   = s2_idx_q;
    if (s1_valid_q) begin
      s2_sof_d  = s1_sof_q;
      s2_data_d = s1_data_q ^ SBOX[s1_ctr_q[7:4]][s1_ctr_q[3:0]];
      s2_idx_d  = s1_idx_q;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
  end

  // State, pipeline and FIFO control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ctr_q      <= 8'h00;
      idx_q      <= 8'h00;
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_data_q  <= 8'h00;
      s1_ctr_q   <= 8'h00;
      s1_idx_q   <= 8'h00;
      s2_valid_q <= 1'b0;
      s2_sof_q   <= 1'b0;
      s2_data_q  <= 8'h00;
      s2_idx_q   <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      s1_valid_q <= s1_valid_d;
      s1_sof_q   <= s1_sof_d;
      s1_data_q  <= s1_data_d;
      s1_ctr_q   <= s1_ctr_d;
      s1_idx_q   <= s1_idx_d;
      s2_valid_q <= s2_valid_d;
      s2_sof_q   <= s2_sof_d;
      s2_data_q  <= s2_data_d;
      s2_idx_q   <= s2_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are only observed through out_valid so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s2_sof_q, s2_idx_q, s2_data_q};
    end
  end

endmodule

// File: tb/tb_hes_stream_decipher.sv
// tb/tb_hes_stream_decipher.sv - scoreboard bench for hes_stream_decipher
module tb_hes_stream_decipher;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic       sof;
    logic [7:0] idx;
    logic [7:0] data;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sof = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_sof;
  logic [7:0] out_index;
  logic       err_orphan;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_sent = 0;
  bit rand_sink = 0;

  logic [7:0] inv_sbox [256];
  ent_t       exp_q[$];
  ent_t       log_q[$];
  int         log_cyc[$];

  hes_stream_decipher #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sof(out_sof), .out_index(out_index), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] l, r;
    l = x << n;
    r = x >> (8 - n);
    return l | r;
  endfunction

  // Inverse S-box derived from GF(2^8) inversion plus the affine map, then inverted
  task automatic build_inv_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0) begin
        for (int b = 1; b < 256; b++) begin
          if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
        end
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_sbox[s] = 8'(a);
    end
  endtask

  // Reference model: message state as key + position, expected plaintext pushed on accept
  bit         m_open = 0;
  logic [7:0] m_key = 8'h00;
  int         m_pos = 0;
  bit         m_orphan_prev = 0;
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      exp_q.delete();
      m_open = 0;
      m_orphan_prev = 0;
    end else begin
      chk("err_orphan", {31'd0, err_orphan}, {31'd0, m_orphan_prev});
      m_orphan_prev = 0;
      if (in_valid && in_ready) begin
        if (in_sof) begin
          m_open = 1;
          m_key = key;
          m_pos = 0;
          exp_q.push_back({1'b1, 8'h00, in_data ^ inv_sbox[key]});
        end else if (m_open) begin
          m_pos++;
          exp_q.push_back({1'b0, 8'(m_pos % 256), in_data ^ inv_sbox[(int'(m_key) + m_pos) % 256]});
        end else begin
          m_orphan_prev = 1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks stall stability
  bit   hold_v = 0;
  ent_t hold_e;
  always @(negedge clk) begin
    ent_t cur, e;
    #4;
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      cur = {out_sof, out_index, out_data};
      if (hold_v) chk("hold_stable", {14'd0, out_valid, cur}, {14'd0, 1'b1, hold_e});
      hold_v = out_valid && !out_ready;
      if (hold_v) hold_e = cur;
      if (out_valid && out_ready) begin
        log_q.push_back(cur);
        log_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h required=none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("out_entry", {15'd0, cur}, {15'd0, e});
        end
      end
    end
  end

  always @(negedge clk) if (rand_sink) out_ready = ($urandom_range(0, 3) != 0);

  task automatic send(input bit sof, input logic [7:0] k, input logic [7:0] d);
    int w;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sof = sof; key = k; in_data = d;
    #1;
    while (!in_ready) begin
      @(negedge clk);
      #1;
      w++;
      if (w > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=stalled required=in_ready");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    n_sent++;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'($urandom); key = 8'($urandom); in_data = 8'($urandom);
    @(posedge clk);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      #4;
      w++;
    end while ((exp_q.size() != 0 || out_valid) && w < 200);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_out_data"}, {24'd0, out_data}, 0);
    chk({tag, "_out_sof"}, {31'd0, out_sof}, 0);
    chk({tag, "_out_index"}, {24'd0, out_index}, 0);
    chk({tag, "_err_orphan"}, {31'd0, err_orphan}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    logic [7:0] ct [4];
    logic [7:0] ctrs [4];
    logic [7:0] c5 [4];
    logic [7:0] k5 [4];

    build_inv_sbox();

    in_valid = 1'b1; in_sof = 1'b1; key = 8'haa; in_data = 8'h55; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", {31'd0, in_ready}, 1);

    // Orphan byte with no open message
    send(1'b0, 8'h12, 8'h34);
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #4;
      chk("orphan_no_out", {31'd0, out_valid}, 0);
    end

    // Latency of a single byte into an empty, unstalled pipe
    send(1'b1, 8'h00, 8'h52);
    n = 0;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #4;
      n++;
      if (out_valid) found = 1;
    end
    chk("latency_windows", n, 3);
    wait_drain();

    // key 0x00 against the leading table bytes
    log_q.delete(); log_cyc.delete();
    send(1'b1, 8'h00, 8'h52);
    send(1'b0, 8'($urandom), 8'h09);
    send(1'b0, 8'($urandom), 8'h6a);
    idle();
    wait_drain();
    chk("k0_count", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      chk("k0_data", {24'd0, log_q[i].data}, 0);
      chk("k0_index", {24'd0, log_q[i].idx}, i);
      chk("k0_sof", {31'd0, log_q[i].sof}, (i == 0) ? 1 : 0);
    end

    // Counter wrap 0xFE -> 0x01
    log_q.delete(); log_cyc.delete();
    ctrs[0] = 8'hfe; ctrs[1] = 8'hff; ctrs[2] = 8'h00; ctrs[3] = 8'h01;
    for (int i = 0; i < 4; i++) ct[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) send(i == 0, (i == 0) ? 8'hfe : 8'($urandom), ct[i]);
    idle();
    wait_drain();
    chk("wrap_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("wrap_index", {24'd0, log_q[i].idx}, i);
      chk("wrap_data", {24'd0, log_q[i].data}, {24'd0, ct[i] ^ inv_sbox[ctrs[i]]});
    end

    // Backpressure: fill with sink stalled, then release for full throughput
    log_q.delete(); log_cyc.delete();
    out_ready = 1'b0;
    n_sent = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(i == 0, 8'h33, 8'(i * 17 + 3));
        idle();
      end
      begin
        repeat (12) @(negedge clk);
        chk("fill_count", n_sent, DEPTH);
        chk("fill_ready", {31'd0, in_ready}, 0);
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_count", log_q.size(), 10);
    for (int i = 1; i < log_q.size(); i++) chk("bp_back_to_back", log_cyc[i] - log_cyc[i-1], 1);

    // Message abandoned by a new sof on the very next cycle
    log_q.delete(); log_cyc.delete();
    for (int i = 0; i < 4; i++) c5[i] = 8'($urandom);
    k5[0] = 8'h10; k5[1] = 8'h11; k5[2] = 8'h20; k5[3] = 8'h21;
    send(1'b1, 8'h10, c5[0]);
    send(1'b0, 8'h77, c5[1]);
    send(1'b1, 8'h20, c5[2]);
    send(1'b0, 8'h77, c5[3]);
    idle();
    wait_drain();
    chk("abandon_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("abandon_data", {24'd0, log_q[i].data}, {24'd0, c5[i] ^ inv_sbox[k5[i]]});
      chk("abandon_index", {24'd0, log_q[i].idx}, i % 2);
      chk("abandon_sof", {31'd0, log_q[i].sof}, (i % 2 == 0) ? 1 : 0);
    end

    // Reset with bytes buffered
    log_q.delete(); log_cyc.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(i == 0, 8'($urandom), 8'($urandom));
    idle();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #4;
      chk("post_reset_no_out", {31'd0, out_valid}, 0);
      chk("post_reset_ready", {31'd0, in_ready}, 1);
    end
    send(1'b0, 8'h5a, 8'ha5);
    idle();
    wait_drain();
    chk("post_reset_log", log_q.size(), 0);

    // Randomized traffic with random sink stalls
    rand_sink = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) idle();
      else send($urandom_range(0, 7) == 0, 8'($urandom), 8'($urandom));
    end
    idle();
    rand_sink = 0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
